// File: rtl/dmem_pkg.sv
// Shared load/store encodings for the data-memory port: access sizes, responder
// states, and the lane-mask / data-steering / extension helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // The reserved encoding behaves as a word when faults are not reported.
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == SZ_RSVD) ? SZ_WORD : size;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << lo;
            SZ_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size,
                                          input logic [31:0] limit);
        logic misaligned;
        misaligned = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        return misaligned || (size == SZ_RSVD) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [3:0]                     be,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory target for the core's load/store port.
// Define DMEM_RESP_ERR_EN to flag misaligned, reserved-size and out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;

    logic        commit;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [31:0] cur_word;
    logic [3:0]  arr_be;
    logic        arr_re;
    logic [AW-1:0] arr_idx;
    logic [31:0] arr_rdata;

    // With zero wait states the commit happens on the accepting edge, so the
    // access is taken straight from the bus instead of the latched copy.
    assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign cur_size  = (state_q == IDLE) ? bus.req_size  : size_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign cur_word  = {2'b00, cur_addr[31:2]};

`ifdef DMEM_RESP_ERR_EN
    assign cur_err = access_fault(cur_addr, cur_size, 32'(4 * DEPTH_WORDS));
`else
    assign cur_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d = cur_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
    end

    // Reset blocks the commit so an aborted store never reaches the array.
    assign arr_be  = (commit && !reset && cur_we && !cur_err)
                     ? lane_mask(eff_size(cur_size), cur_addr[1:0]) : 4'b0000;
    assign arr_re  = commit && !reset && !cur_we && !cur_err;
    assign arr_idx = AW'(cur_word % 32'(DEPTH_WORDS));

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .be    (arr_be),
        .re    (arr_re),
        .idx   (arr_idx),
        .wdata (store_lanes(cur_wdata, eff_size(cur_size))),
        .rdata (arr_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q)
                           ? load_extend(arr_rdata, eff_size(size_q), addr_q[1:0], uns_q) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: one WAIT_CYCLES=1 instance, one zero-wait instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mdl [4*DEPTH];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_if bus ();
    dmem_if busz ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .bus(busz)
    );

    // Byte-addressed reference memory; returns {err, rdata}.
    task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd, output logic [32:0] r);
        int nb, base;
        logic [1:0] m, lo;
        logic [31:0] v;
        logic err;
        nb  = (sz == 2'b11) ? 4 : (1 << sz);
        m   = 2'(nb - 1);
        lo  = a[1:0] & ~m;
        err = 1'b0;
`ifdef DMEM_RESP_ERR_EN
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || a >= 32'(4*DEPTH))
            err = 1'b1;
`endif
        base = int'(((a >> 2) % DEPTH) * 4) + int'(lo);
        v = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[base+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[base+i];
                if (!uns && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
            end
        end
        r = {err, v};
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
        logic [32:0] e, got;
        logic [31:0] rd0;
        int n;
        model_access(we, a, sz, uns, wd, e);
        exp_q.push_back(e);
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got %b need 1", bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
        bus.req_size = sz; bus.req_unsigned = uns; bus.req_wdata = wd;
        @(posedge clk); #1;
        // Keep a bogus request on the bus while busy; it must be ignored.
        bus.req_we = ~we; bus.req_addr = $urandom(); bus.req_wdata = $urandom(); bus.req_size = 2'($urandom());
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!bus.rsp_valid) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL busy_req_ready got %b need 0", bus.req_ready); end
            end
        end while (!bus.rsp_valid && n < 20);
        checks++;
        if (n != 2) begin errors++; $display("FAIL latency got %0d need 2 cycles", n); end
        rd0 = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd0 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable got valid=%b rdata=%h ready=%b need 1/%h/0",
                         bus.rsp_valid, bus.rsp_rdata, bus.req_ready, rd0);
            end
            @(negedge clk);
        end
        got = {bus.rsp_err, bus.rsp_rdata};
        rd = bus.rsp_rdata; er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL scoreboard addr=%h got err=%b rdata=%h need err=%b rdata=%h", a, got[32], got[31:0], e[32], e[31:0]); end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL back_to_idle got ready=%b valid=%b need 1/0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin errors++; $display("FAIL %s got %h need %h", name, got, need); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
        busz.req_valid = 0; busz.req_we = 0; busz.req_addr = 0; busz.req_size = 0;
        busz.req_unsigned = 0; busz.req_wdata = 0; busz.rsp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b100 || bus.rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_state got %b%b%b/%h need 100/0", bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        checks++;
        if ({busz.req_ready, busz.rsp_valid, busz.rsp_err} !== 3'b100 || busz.rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_state_z got %b%b%b/%h need 100/0", busz.req_ready, busz.rsp_valid, busz.rsp_err, busz.rsp_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] rd; logic er;
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(4*i), SZ_WORD, 1'b0, $urandom(), 0, rd, er);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, 0, rd, er);
        expect32("store_rdata_zero", rd, 32'd0);
        do_req(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("lw_10", rd, 32'hDEADBEEF);
        expect32("lw_10_err", {31'd0, er}, 32'd0);
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er;
        do_req(1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0, 0, rd, er); expect32("lb_13", rd, 32'hFFFFFFDE);
        do_req(1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0, 0, rd, er); expect32("lbu_13", rd, 32'h000000DE);
        do_req(1'b0, 32'h12, SZ_HALF, 1'b0, 32'h0, 0, rd, er); expect32("lh_12", rd, 32'hFFFFDEAD);
        do_req(1'b1, 32'h11, SZ_BYTE, 1'b0, 32'hAAAAAA55, 0, rd, er);
        do_req(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 0, rd, er); expect32("lw_after_sb", rd, 32'hDEAD55EF);
        do_req(1'b1, 32'h12, SZ_HALF, 1'b0, 32'hBBBB1234, 0, rd, er);
        do_req(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 0, rd, er); expect32("lw_after_sh", rd, 32'h123455EF);
        do_req(1'b0, 32'h10, SZ_HALF, 1'b1, 32'h0, 0, rd, er); expect32("lhu_10", rd, 32'h000055EF);
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er;
        do_req(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 5, rd, er);
        expect32("lw_backpressure", rd, 32'h123455EF);
    endtask

    task automatic test_wait0();
        logic        we_t [2] = '{1'b1, 1'b0};
        logic [31:0] need [2] = '{32'd0, 32'hA5A50F0F};
        int n;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            busz.req_valid = 1'b1; busz.req_we = we_t[t]; busz.req_addr = 32'h8;
            busz.req_size = SZ_WORD; busz.req_unsigned = 1'b0; busz.req_wdata = 32'hA5A50F0F;
            @(posedge clk); #1;
            busz.req_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!busz.rsp_valid && n < 10);
            checks++;
            if (n != 1) begin errors++; $display("FAIL wait0_latency got %0d need 1", n); end
            expect32("wait0_rdata", busz.rsp_rdata, need[t]);
            busz.rsp_ready = 1'b1;
            @(posedge clk); #1;
            busz.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, prior; logic er;
`ifdef DMEM_RESP_ERR_EN
        do_req(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 0, prior, er);
        do_req(1'b1, 32'h22, SZ_WORD, 1'b0, 32'hCAFEBABE, 0, rd, er);
        expect32("misaligned_store_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("mem_unchanged", rd, prior);
        do_req(1'b0, 32'(4*DEPTH), SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("oob_err", {31'd0, er}, 32'd1);
        expect32("oob_rdata", rd, 32'd0);
        do_req(1'b0, 32'h20, SZ_RSVD, 1'b0, 32'h0, 0, rd, er);
        expect32("rsvd_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 32'h21, SZ_HALF, 1'b0, 32'h0, 0, rd, er);
        expect32("half_odd_err", {31'd0, er}, 32'd1);
`else
        do_req(1'b1, 32'h22, SZ_WORD, 1'b0, 32'hCAFEBABE, 0, rd, er);
        expect32("misaligned_store_noerr", {31'd0, er}, 32'd0);
        do_req(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("aligned_down_store", rd, 32'hCAFEBABE);
        do_req(1'b0, 32'h120, SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("index_wrap", rd, 32'hCAFEBABE);
        do_req(1'b0, 32'h20, SZ_RSVD, 1'b0, 32'h0, 0, rd, er);
        expect32("rsvd_as_word", rd, 32'hCAFEBABE);
        do_req(1'b0, 32'h23, SZ_HALF, 1'b0, 32'h0, 0, rd, er);
        expect32("half_aligned_down", rd, 32'hFFFFCAFE);
        prior = rd;
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er;
        do_req(1'b1, 32'h40, SZ_WORD, 1'b0, 32'h11223344, 0, rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h40;
        bus.req_size = SZ_WORD; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait got ready=%b valid=%b need 1/0", bus.req_ready, bus.rsp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL no_response_after_abort got %b need 0", bus.rsp_valid); end
        end
        do_req(1'b0, 32'h40, SZ_WORD, 1'b0, 32'h0, 0, rd, er);
        expect32("aborted_store_not_written", rd, 32'h11223344);
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er;
        for (int i = 0; i < 40; i++)
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom(), 0, rd, er);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_subword();
        test_backpressure();
        test_wait0();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
